// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES input loader: FSM state encoding and block geometry.
package aes_pkg;

   localparam int AES_BLK_W     = 128;
   localparam int WORDS_PER_BLK = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD_KEY,
      ST_LOAD_DATA,
      ST_RUN
   } loader_state_e;

endpackage

// File: rtl/aes_input_loader_if.sv
// Command and word-stream port of aes_input_loader, with master/slave views.
interface aes_input_loader_if #(parameter int WORD_W = 32);

   // Handshake: a word transfers on a rising edge where in_valid && in_ready are both high.
   // The master holds in_word stable while in_valid is high and in_ready is low.
   // cmd_start is a one-cycle request, and cmd_new_key is sampled with it.
   logic              cmd_start;
   logic              cmd_new_key;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_word;

   modport master (output cmd_start, cmd_new_key, in_valid, in_word, input in_ready);
   modport slave  (input cmd_start, cmd_new_key, in_valid, in_word, output in_ready);

endinterface

// File: rtl/aes_word_packer.sv
// Four-word shift register with a wrapping word counter. It assembles one 128-bit operand, first word in the MSBs.
module aes_word_packer
   import aes_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic [WORD_W-1:0]    word_i,
   output logic [AES_BLK_W-1:0] blk_o,
   output logic                 full_o
);

   logic [AES_BLK_W-1:0] shadow_q, shadow_d;
   logic [1:0]           cnt_q, cnt_d;

   always_comb begin
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      if (en_i) begin
         shadow_d = {shadow_q[AES_BLK_W-WORD_W-1:0], word_i};
         cnt_d    = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_q <= '0;
         cnt_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
      end
   end

   // blk_o already contains a word that is being accepted this cycle.
   // This lets the owner capture the complete block on the edge that takes the 4th word.
   assign blk_o  = shadow_d;
   assign full_o = en_i && (cnt_q == 2'(WORDS_PER_BLK - 1));

endmodule

// File: rtl/aes_input_loader.sv
// Assembles the key and plaintext from a 32-bit word stream and drives the AES core until it completes.
// Defining LOADER_TIMEOUT_EN adds an abort after TIMEOUT_CYC cycles in RUN.
module aes_input_loader
   import aes_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                 AES_clk,
   input  logic                 AES_rst_n,
   aes_input_loader_if.slave    in_if,
   input  logic                 AES_data_out_valid,
   output logic                 AES_en,
   output logic [AES_BLK_W-1:0] AES_data_in,
   output logic [AES_BLK_W-1:0] AES_key_in,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout_err,
   output loader_state_e        dbg_state_o
);

   loader_state_e        state_q, state_d;
   logic                 in_ready_q, in_ready_d;
   logic                 key_loaded_q, key_loaded_d;
   logic                 key_this_blk_q, key_this_blk_d;
   logic                 en_q, en_d;
   logic                 done_q, done_d;
   logic                 tmo_err_q, tmo_err_d;
   logic [AES_BLK_W-1:0] data_out_q, data_out_d;
   logic [AES_BLK_W-1:0] key_out_q, key_out_d;
   logic                 accept, key_en, data_en, key_full, data_full, tmo_hit;
   logic [AES_BLK_W-1:0] key_blk, data_blk;

   assign accept  = in_if.in_valid && in_ready_q;
   assign key_en  = accept && (state_q == ST_LOAD_KEY);
   assign data_en = accept && (state_q == ST_LOAD_DATA);

   aes_word_packer #(.WORD_W(WORD_W)) u_key_packer (
      .clk_i (AES_clk), .rst_ni (AES_rst_n), .en_i (key_en),
      .word_i (in_if.in_word), .blk_o (key_blk), .full_o (key_full)
   );

   aes_word_packer #(.WORD_W(WORD_W)) u_data_packer (
      .clk_i (AES_clk), .rst_ni (AES_rst_n), .en_i (data_en),
      .word_i (in_if.in_word), .blk_o (data_blk), .full_o (data_full)
   );

`ifdef LOADER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt_q;

   // The counter is held at zero outside RUN, so it starts from zero on each RUN entry.
   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n)              tmo_cnt_q <= '0;
      else if (state_q == ST_RUN)  tmo_cnt_q <= tmo_cnt_q + 1'b1;
      else                         tmo_cnt_q <= '0;
   end

   assign tmo_hit = (state_q == ST_RUN) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYC > 0);
   assign tmo_hit    = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      key_loaded_d   = key_loaded_q;
      key_this_blk_d = key_this_blk_q;
      en_d           = en_q;
      done_d         = 1'b0;
      tmo_err_d      = 1'b0;
      data_out_d     = data_out_q;
      key_out_d      = key_out_q;
      case (state_q)
         ST_IDLE: begin
            if (in_if.cmd_start) begin
               key_this_blk_d = in_if.cmd_new_key || !key_loaded_q;
               state_d        = key_this_blk_d ? ST_LOAD_KEY : ST_LOAD_DATA;
            end
         end
         ST_LOAD_KEY: begin
            if (key_full) begin
               state_d      = ST_LOAD_DATA;
               key_loaded_d = 1'b1;
            end
         end
         ST_LOAD_DATA: begin
            if (data_full) begin
               state_d    = ST_RUN;
               en_d       = 1'b1;
               data_out_d = data_blk;
               if (key_this_blk_q) key_out_d = key_blk;
            end
         end
         ST_RUN: begin
            // If completion and timeout occur in the same cycle, completion wins.
            if (AES_data_out_valid) begin
               state_d = ST_IDLE;
               en_d    = 1'b0;
               done_d  = 1'b1;
            end else if (tmo_hit) begin
               state_d   = ST_IDLE;
               en_d      = 1'b0;
               tmo_err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d = ((state_q == ST_LOAD_KEY) || (state_q == ST_LOAD_DATA)) && !(key_full || data_full);
   end

   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         state_q        <= ST_IDLE;
         in_ready_q     <= 1'b0;
         key_loaded_q   <= 1'b0;
         key_this_blk_q <= 1'b0;
         en_q           <= 1'b0;
         done_q         <= 1'b0;
         tmo_err_q      <= 1'b0;
         data_out_q     <= '0;
         key_out_q      <= '0;
      end else begin
         state_q        <= state_d;
         in_ready_q     <= in_ready_d;
         key_loaded_q   <= key_loaded_d;
         key_this_blk_q <= key_this_blk_d;
         en_q           <= en_d;
         done_q         <= done_d;
         tmo_err_q      <= tmo_err_d;
         data_out_q     <= data_out_d;
         key_out_q      <= key_out_d;
      end
   end

   assign in_if.in_ready = in_ready_q;
   assign AES_en         = en_q;
   assign AES_data_in    = data_out_q;
   assign AES_key_in     = key_out_q;
   assign busy           = (state_q != ST_IDLE);
   assign done           = done_q;
   assign timeout_err    = tmo_err_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_aes_input_loader.sv
// Directed bench for aes_input_loader: key load, key reuse, backpressure, reset mid-load, and timeout (with LOADER_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_aes_input_loader;
   import aes_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_input_loader_if #(.WORD_W(32)) bus ();
   logic          aes_valid;
   logic          aes_en;
   logic [127:0]  data_in, key_in;
   logic          busy, done, tmo_err;
   loader_state_e dbg_state;

   aes_input_loader #(.WORD_W(32), .TIMEOUT_CYC(64)) dut (
      .AES_clk            (clk),
      .AES_rst_n          (rst_n),
      .in_if              (bus.slave),
      .AES_data_out_valid (aes_valid),
      .AES_en             (aes_en),
      .AES_data_in        (data_in),
      .AES_key_in         (key_in),
      .busy               (busy),
      .done               (done),
      .timeout_err        (tmo_err),
      .dbg_state_o        (dbg_state)
   );

   // ---------------- scoreboard / monitors ----------------
   logic [255:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int hs_cnt  = 0;
   bit tmo_seen = 1'b0;

   always @(posedge clk) if (bus.in_valid && bus.in_ready) hs_cnt++;
   always @(posedge clk) if (tmo_err) tmo_seen = 1'b1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input loader_state_e exp);
      check(tag, 128'(dbg_state), 128'(exp));
   endtask

   // ---------------- driver tasks ----------------
   task automatic cmd(input bit new_key);
      bus.cmd_start   = 1'b1;
      bus.cmd_new_key = new_key;
      @(negedge clk);
      bus.cmd_start   = 1'b0;
      bus.cmd_new_key = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gappy);
      int budget;
      if (gappy) begin
         bus.in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_word  = w;
      budget = 20;
      while (!bus.in_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("in_ready_wait", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic load_words(input logic [127:0] blk, input bit gappy);
      send_word(blk[127:96], gappy);
      send_word(blk[95:64],  gappy);
      send_word(blk[63:32],  gappy);
      send_word(blk[31:0],   gappy);
   endtask

   task automatic check_outputs(input string tag);
      logic [255:0] e;
      check({tag, "_en"}, aes_en, 1);
      check({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_key"},  key_in,  e[255:128]);
         check({tag, "_data"}, data_in, e[127:0]);
      end
   endtask

   task automatic core_reply(input int lat);
      repeat (lat - 1) @(negedge clk);
      aes_valid = 1'b1;
      @(negedge clk);
      aes_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   localparam logic [127:0] KEY1  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
   localparam logic [127:0] DATA1 = 128'h00000081_00000000_00000000_00000000;
   localparam logic [127:0] DATA2 = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;

   initial begin
      logic [127:0] key4, data4, data3;
      int hs0;
      int cnt;
      bus.cmd_start = 1'b0; bus.cmd_new_key = 1'b0;
      bus.in_valid = 1'b0;  bus.in_word = '0;
      aes_valid = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_en", aes_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_data", data_in, 0);
      check("rst_key", key_in, 0);
      check("rst_tmo", tmo_err, 0);
      check_state("rst_state", ST_IDLE);
      rst_n = 1'b1;
      @(negedge clk);

      // Completion from the core outside RUN must be ignored
      aes_valid = 1'b1;
      @(negedge clk);
      aes_valid = 1'b0;
      check("idle_valid_done", done, 0);
      check_state("idle_valid_state", ST_IDLE);

      // Block 1: new key, reference vectors
      hs0 = hs_cnt;
      cmd(1'b1);
      check_state("b1_load_key", ST_LOAD_KEY);
      check("b1_ready_lag", bus.in_ready, 0);
      load_words(KEY1, 1'b0);
      exp_q.push_back({KEY1, DATA1});
      load_words(DATA1, 1'b0);
      check_outputs("b1");
      check("b1_hs", hs_cnt - hs0, 8);
      check("b1_ready_run", bus.in_ready, 0);
      core_reply(51);
      check("b1_en_off", aes_en, 0);
      check("b1_done", done, 1);
      check("b1_busy", busy, 0);
      @(negedge clk);
      check("b1_done_pulse", done, 0);
      check("b1_key_hold", key_in, KEY1);

      // Block 2: key reuse
      hs0 = hs_cnt;
      cmd(1'b0);
      check_state("b2_load_data", ST_LOAD_DATA);
      exp_q.push_back({KEY1, DATA2});
      load_words(DATA2, 1'b0);
      check_outputs("b2");
      check("b2_hs", hs_cnt - hs0, 4);
`ifndef LOADER_TIMEOUT_EN
      repeat (79) @(negedge clk);
      check("b2_en_long", aes_en, 1);
`endif
      core_reply(10);
      check("b2_done", done, 1);
      @(negedge clk);

      // Reset after 2 data words: clears everything and drops the loaded key
      data3 = {$urandom, $urandom, $urandom, $urandom};
      cmd(1'b0);
      send_word(data3[127:96], 1'b0);
      send_word(data3[95:64], 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_en", aes_en, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", bus.in_ready, 0);
      check("mid_rst_data", data_in, 0);
      check("mid_rst_key", key_in, 0);
      check_state("mid_rst_state", ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cmd(1'b0);
      check_state("post_rst_forced_key", ST_LOAD_KEY);

      // Block 4: random words with backpressure
      key4  = {$urandom, $urandom, $urandom, $urandom};
      data4 = {$urandom, $urandom, $urandom, $urandom};
      hs0 = hs_cnt;
      load_words(key4, 1'b1);
      exp_q.push_back({key4, data4});
      load_words(data4, 1'b1);
      check_outputs("b4");
      bus.in_valid = 1'b1;
      bus.in_word  = 32'hdeadbeef;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      check("b4_hs", hs_cnt - hs0, 8);
      check("b4_ready_run", bus.in_ready, 0);
      cmd(1'b1);
      check_state("b4_cmd_in_run", ST_RUN);
      check("b4_en_hold", aes_en, 1);
      check("b4_data_hold", data_in, data4);
      check("b4_key_hold", key_in, key4);
      core_reply(5);
      check("b4_done", done, 1);
      @(negedge clk);

`ifdef LOADER_TIMEOUT_EN
      // Timeout: the core never answers
      cmd(1'b0);
      exp_q.push_back({key4, DATA2});
      load_words(DATA2, 1'b0);
      check_outputs("tmo");
      cnt = 0;
      while (aes_en && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      check("tmo_cycles", cnt, 64);
      check("tmo_err_pulse", tmo_err, 1);
      check("tmo_done", done, 0);
      check_state("tmo_state", ST_IDLE);
      @(negedge clk);
      check("tmo_err_clear", tmo_err, 0);
`else
      cnt = 0;
      check("tmo_never", tmo_seen, 0);
`endif

      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
